// File: rtl/turnstile_fare_ctrl.sv
// Fare-collecting turnstile: accumulates coin credit, unlocks at FARE, deducts per pass, relocks on idle.
// Optional build macro TURNSTILE_REFUND_EN adds a refund request/return path.
module turnstile_fare_ctrl #(
  parameter int VALUE_W        = 4,
  parameter int CREDIT_W       = 8,
  parameter int FARE           = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COUNT_W        = 16
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Coin_Valid,
  input  logic [VALUE_W-1:0]  i_Coin_Value,
  input  logic                i_Push,
`ifdef TURNSTILE_REFUND_EN
  input  logic                i_Refund,
  output logic                o_Refund_Valid,
  output logic [CREDIT_W-1:0] o_Refund_Value,
`endif
  output logic                o_Locked,
  output logic [CREDIT_W-1:0] o_Credit,
  output logic [COUNT_W-1:0]  o_Pass_Count,
  output logic                o_Alarm,
  output logic                o_Coin_Reject,
  output logic                o_Timeout
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CREDIT_W-1:0] FARE_C   = CREDIT_W'(FARE);
  localparam logic [TMR_W-1:0]    TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {LOCKED = 1'b0, UNLOCKED = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  push_prev_q;
  logic                  alarm_q, alarm_d;
  logic                  reject_q, reject_d;
  logic                  timeout_q, timeout_d;
`ifdef TURNSTILE_REFUND_EN
  logic                  refund_vld_q, refund_vld_d;
  logic [CREDIT_W-1:0]   refund_val_q, refund_val_d;
`endif

  logic                  push_evt;
  logic                  idle;
  logic [CREDIT_W-1:0]   credit_pc;
  logic [SUM_W-1:0]      coin_sum;

  // Sum carried one bit wider than the credit so an overflow is visible instead of wrapping.
  function automatic logic [SUM_W-1:0] add_coin(input logic [CREDIT_W-1:0] credit,
                                                input logic [VALUE_W-1:0]  value);
    add_coin = {1'b0, credit} + SUM_W'(value);
  endfunction

  function automatic logic coin_overflows(input logic [SUM_W-1:0] sum);
    coin_overflows = sum[SUM_W-1];
  endfunction

  assign push_evt = i_Push & ~push_prev_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= LOCKED;
      credit_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      push_prev_q  <= 1'b1;
      alarm_q      <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef TURNSTILE_REFUND_EN
      refund_vld_q <= 1'b0;
      refund_val_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      push_prev_q  <= i_Push;
      alarm_q      <= alarm_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
`ifdef TURNSTILE_REFUND_EN
      refund_vld_q <= refund_vld_d;
      refund_val_q <= refund_val_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = '0;
    alarm_d   = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    credit_pc = credit_q;
    idle      = 1'b0;
`ifdef TURNSTILE_REFUND_EN
    refund_vld_d = 1'b0;
    refund_val_d = '0;
`endif

    // Push first: an unlocked state guarantees credit >= FARE, so the subtraction cannot underflow.
    case (state_q)
      UNLOCKED: begin
        if (push_evt) begin
          credit_pc = credit_q - FARE_C;
          count_d   = count_q + COUNT_W'(1);
        end
        idle = ~push_evt & ~i_Coin_Valid;
      end
      default: begin
        if (push_evt) alarm_d = 1'b1;
      end
    endcase

    coin_sum = add_coin(credit_pc, i_Coin_Value);
    if (i_Coin_Valid) begin
      if (coin_overflows(coin_sum)) reject_d = 1'b1;
      else                          credit_pc = coin_sum[CREDIT_W-1:0];
    end
    credit_d = credit_pc;

    if (idle) begin
      if (timer_q == TMO_LAST) begin
        timeout_d = 1'b1;
        credit_d  = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

`ifdef TURNSTILE_REFUND_EN
    // Timeout returns the credit instead of forfeiting it; an explicit request does the same.
    if (timeout_d) begin
      refund_vld_d = 1'b1;
      refund_val_d = credit_pc;
    end else if (i_Refund && (credit_pc != '0)) begin
      refund_vld_d = 1'b1;
      refund_val_d = credit_pc;
      credit_d     = '0;
    end
`endif

    state_d = (credit_d >= FARE_C) ? UNLOCKED : LOCKED;
    if (state_d == LOCKED) timer_d = '0;
  end

  assign o_Locked      = (state_q == LOCKED);
  assign o_Credit      = credit_q;
  assign o_Pass_Count  = count_q;
  assign o_Alarm       = alarm_q;
  assign o_Coin_Reject = reject_q;
  assign o_Timeout     = timeout_q;
`ifdef TURNSTILE_REFUND_EN
  assign o_Refund_Valid = refund_vld_q;
  assign o_Refund_Value = refund_val_q;
`endif

endmodule

// File: tb/tb_turnstile_fare_ctrl.sv
// Bench for turnstile_fare_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural credit/fare model.
module tb_turnstile_fare_ctrl;

  localparam int VALUE_W  = 4;
  localparam int CREDIT_W = 8;
  localparam int FARE     = 3;
  localparam int TMO      = 20;
  localparam int COUNT_W  = 16;
  localparam int CMAX     = (1 << CREDIT_W) - 1;

  logic                i_Clk = 1'b0;
  logic                i_Reset = 1'b1;
  logic                i_Coin_Valid = 1'b0;
  logic [VALUE_W-1:0]  i_Coin_Value = '0;
  logic                i_Push = 1'b0;
  logic                o_Locked;
  logic [CREDIT_W-1:0] o_Credit;
  logic [COUNT_W-1:0]  o_Pass_Count;
  logic                o_Alarm;
  logic                o_Coin_Reject;
  logic                o_Timeout;
`ifdef TURNSTILE_REFUND_EN
  logic                i_Refund = 1'b0;
  logic                o_Refund_Valid;
  logic [CREDIT_W-1:0] o_Refund_Value;
`endif

  turnstile_fare_ctrl #(
    .VALUE_W(VALUE_W), .CREDIT_W(CREDIT_W), .FARE(FARE),
    .TIMEOUT_CYCLES(TMO), .COUNT_W(COUNT_W)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Coin_Valid(i_Coin_Valid), .i_Coin_Value(i_Coin_Value), .i_Push(i_Push),
`ifdef TURNSTILE_REFUND_EN
    .i_Refund(i_Refund), .o_Refund_Valid(o_Refund_Valid), .o_Refund_Value(o_Refund_Value),
`endif
    .o_Locked(o_Locked), .o_Credit(o_Credit), .o_Pass_Count(o_Pass_Count),
    .o_Alarm(o_Alarm), .o_Coin_Reject(o_Coin_Reject), .o_Timeout(o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  // Reference state: what the turnstile should show after each clock edge.
  int m_ok = 0;
  int m_credit, m_count, m_unl, m_idle, m_prev;
  int m_alarm, m_rej, m_tmo, m_rv, m_rval;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int ev;
    if (i_Reset) begin
      m_ok = 1; m_credit = 0; m_count = 0; m_unl = 0; m_idle = 0; m_prev = 1;
      m_alarm = 0; m_rej = 0; m_tmo = 0; m_rv = 0; m_rval = 0;
      return;
    end
    ev = (i_Push && m_prev == 0) ? 1 : 0;
    m_prev = i_Push ? 1 : 0;
    m_alarm = 0; m_rej = 0; m_tmo = 0; m_rv = 0; m_rval = 0;
    if (ev == 1) begin
      if (m_unl == 1) begin
        m_credit = m_credit - FARE;
        m_count  = (m_count + 1) % (1 << COUNT_W);
      end else begin
        m_alarm = 1;
      end
    end
    if (i_Coin_Valid) begin
      if (m_credit + int'(i_Coin_Value) > CMAX) m_rej = 1;
      else m_credit = m_credit + int'(i_Coin_Value);
    end
    if (m_unl == 1 && ev == 0 && !i_Coin_Valid) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_tmo = 1;
        m_idle = 0;
        m_rv = 1;
        m_rval = m_credit;
        m_credit = 0;
      end
    end else begin
      m_idle = 0;
    end
`ifdef TURNSTILE_REFUND_EN
    if (m_tmo == 0 && i_Refund && m_credit > 0) begin
      m_rv = 1; m_rval = m_credit; m_credit = 0;
    end
`else
    m_rv = 0; m_rval = 0;
`endif
    m_unl = (m_credit >= FARE) ? 1 : 0;
    if (m_unl == 0) m_idle = 0;
  endtask

  initial begin
    forever begin
      @(posedge i_Clk);
      model_step();
      #1;
      if (m_ok == 1 && !done) begin
        chk("locked",  32'(o_Locked),      32'(1 - m_unl));
        chk("credit",  32'(o_Credit),      32'(m_credit));
        chk("count",   32'(o_Pass_Count),  32'(m_count));
        chk("alarm",   32'(o_Alarm),       32'(m_alarm));
        chk("reject",  32'(o_Coin_Reject), 32'(m_rej));
        chk("timeout", 32'(o_Timeout),     32'(m_tmo));
`ifdef TURNSTILE_REFUND_EN
        chk("refund_vld", 32'(o_Refund_Valid), 32'(m_rv));
        chk("refund_val", 32'(o_Refund_Value), 32'(m_rval));
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

  task automatic coin(input int v);
    i_Coin_Valid = 1'b1;
    i_Coin_Value = VALUE_W'(v);
    @(negedge i_Clk);
    i_Coin_Valid = 1'b0;
    i_Coin_Value = '0;
  endtask

  task automatic idle_to_timeout(input string nm, input int exp_credit);
    repeat (TMO - 1) @(negedge i_Clk);
    chk({nm, "_pre_timeout"}, 32'(o_Timeout), 0);
    chk({nm, "_pre_credit"},  32'(o_Credit),  32'(exp_credit));
    @(negedge i_Clk);
    chk({nm, "_timeout"}, 32'(o_Timeout), 1);
    chk({nm, "_credit"},  32'(o_Credit),  0);
    chk({nm, "_locked"},  32'(o_Locked),  1);
`ifdef TURNSTILE_REFUND_EN
    chk({nm, "_refund_vld"}, 32'(o_Refund_Valid), 1);
    chk({nm, "_refund_val"}, 32'(o_Refund_Value), 32'(exp_credit));
`endif
  endtask

  initial begin
    int mode;
    repeat (2) @(negedge i_Clk);
    chk("rst_locked", 32'(o_Locked), 1);
    chk("rst_credit", 32'(o_Credit), 0);
    chk("rst_count",  32'(o_Pass_Count), 0);
    chk("rst_alarm",  32'(o_Alarm), 0);
    chk("rst_timeout", 32'(o_Timeout), 0);
    i_Reset = 1'b0;
    @(negedge i_Clk);

    // Push while locked raises the alarm only.
    i_Push = 1'b1; @(negedge i_Clk);
    chk("alarm_pulse", 32'(o_Alarm), 1);
    chk("alarm_locked", 32'(o_Locked), 1);
    chk("alarm_credit", 32'(o_Credit), 0);
    i_Push = 1'b0; @(negedge i_Clk);
    chk("alarm_clear", 32'(o_Alarm), 0);

    coin(1); coin(1);
    chk("two_coins_credit", 32'(o_Credit), 2);
    chk("two_coins_locked", 32'(o_Locked), 1);
    coin(1);
    chk("fare_unlock", 32'(o_Locked), 0);
    chk("fare_credit", 32'(o_Credit), 3);
    i_Push = 1'b1; @(negedge i_Clk);
    chk("pass1_credit", 32'(o_Credit), 0);
    chk("pass1_count",  32'(o_Pass_Count), 1);
    chk("pass1_locked", 32'(o_Locked), 1);
    repeat (10) @(negedge i_Clk);
    chk("hold_count", 32'(o_Pass_Count), 1);
    i_Push = 1'b0; @(negedge i_Clk);

    coin(5); coin(2);
    chk("c7_credit", 32'(o_Credit), 7);
    chk("c7_locked", 32'(o_Locked), 0);
    i_Push = 1'b1; @(negedge i_Clk);
    chk("pass2_credit", 32'(o_Credit), 4);
    chk("pass2_locked", 32'(o_Locked), 0);
    chk("pass2_count",  32'(o_Pass_Count), 2);
    i_Push = 1'b0; @(negedge i_Clk);
    i_Push = 1'b1; @(negedge i_Clk);
    chk("pass3_credit", 32'(o_Credit), 1);
    chk("pass3_locked", 32'(o_Locked), 1);
    chk("pass3_count",  32'(o_Pass_Count), 3);
    i_Push = 1'b0; @(negedge i_Clk);

    // Fill to 250, then probe the overflow boundary.
    repeat (16) coin(15);
    coin(9);
    chk("fill_credit", 32'(o_Credit), 250);
    coin(8);
    chk("ovf_reject", 32'(o_Coin_Reject), 1);
    chk("ovf_credit", 32'(o_Credit), 250);
    coin(5);
    chk("max_reject", 32'(o_Coin_Reject), 0);
    chk("max_credit", 32'(o_Credit), 255);
    idle_to_timeout("tmo255", 255);

    coin(3);
    chk("c3_locked", 32'(o_Locked), 0);
    idle_to_timeout("tmo3", 3);

    // Reset with push held: nothing counted on release of reset.
    coin(5);
    chk("c5_locked", 32'(o_Locked), 0);
    i_Push = 1'b1; i_Reset = 1'b1; @(negedge i_Clk);
    chk("midrst_locked", 32'(o_Locked), 1);
    chk("midrst_credit", 32'(o_Credit), 0);
    chk("midrst_count",  32'(o_Pass_Count), 0);
    i_Reset = 1'b0; @(negedge i_Clk);
    chk("postrst_count", 32'(o_Pass_Count), 0);
    chk("postrst_alarm", 32'(o_Alarm), 0);
    i_Push = 1'b0; @(negedge i_Clk);

    // Randomized traffic: quiet (timeouts), busy, and fill (overflow) phases.
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 40; c++) begin
        i_Reset = ($urandom_range(0, 299) == 0);
        case (mode)
          0: begin
            i_Coin_Valid = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 39) == 0) i_Push = ~i_Push;
          end
          1: begin
            i_Coin_Valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) i_Push = ~i_Push;
          end
          default: begin
            i_Coin_Valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) i_Push = ~i_Push;
          end
        endcase
        i_Coin_Value = VALUE_W'($urandom_range(0, 15));
`ifdef TURNSTILE_REFUND_EN
        i_Refund = ($urandom_range(0, 24) == 0);
`endif
        @(negedge i_Clk);
      end
    end
    i_Reset = 1'b0; i_Coin_Valid = 1'b0; i_Push = 1'b0;
`ifdef TURNSTILE_REFUND_EN
    i_Refund = 1'b0;
`endif
    @(negedge i_Clk);
    done = 1'b1;
    @(negedge i_Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
